parking_sensor_gen: RTL and testbench

PARKING_SENSOR_GEN -- requirements
Module: parking_sensor_gen

---
 rtl/parking_sensor_gen_pkg.sv | 50 +++++
 rtl/parking_sensor_gen_if.sv | 38 +++
 rtl/parking_sensor_gen_dwell_timer.sv | 49 ++++
 rtl/parking_sensor_gen.sv | 191 +++++++++++++++++++
 tb/tb_parking_sensor_gen.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/parking_sensor_gen_pkg.sv
// ---------------------------------------------------------------------------
// parking_pkg
// Shared definitions for the parking sensor generator.
//   - beam patterns {a,b} (1 = beam blocked)
//   - direction encoding
//   - FSM state encoding
//   - phase_ab(): maps a state and direction to the sensor pattern
// Optional feature macro: PARKING_SENSOR_GEN_ABORT_EN adds the back-out states.
// ---------------------------------------------------------------------------
package parking_pkg;

  localparam logic [1:0] AB_NONE = 2'b00;
  localparam logic [1:0] AB_A    = 2'b10;
  localparam logic [1:0] AB_BOTH = 2'b11;
  localparam logic [1:0] AB_B    = 2'b01;

  localparam logic DIR_ENTRY = 1'b0;
  localparam logic DIR_EXIT  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_P1      = 3'd1,
    ST_P2      = 3'd2,
    ST_P3      = 3'd3,
    ST_DONE    = 3'd4
`ifdef PARKING_SENSOR_GEN_ABORT_EN
    ,
    ST_BACK2   = 3'd5,
    ST_BACK1   = 3'd6,
    ST_ABORTED = 3'd7
`endif
  } state_e;

  // Back-out phases reuse the forward patterns of the phase being retreated into.
  function automatic logic [1:0] phase_ab(input state_e st, input logic dir);
    logic [1:0] pat;
    case (st)
      ST_P1:    pat = (dir == DIR_ENTRY) ? AB_A : AB_B;
      ST_P2:    pat = AB_BOTH;
      ST_P3:    pat = (dir == DIR_ENTRY) ? AB_B : AB_A;
`ifdef PARKING_SENSOR_GEN_ABORT_EN
      ST_BACK2: pat = AB_BOTH;
      ST_BACK1: pat = (dir == DIR_ENTRY) ? AB_A : AB_B;
`endif
      default:  pat = AB_NONE;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/parking_sensor_gen_if.sv
// ---------------------------------------------------------------------------
// parking_sensor_gen_if
// Request/response bundle of the parking sensor generator.
//   master (requester): drives start, dir, dwell (and abort); observes the rest
//   slave  (generator): drives ready, ab, busy, done (and aborted)
// Optional feature macro: PARKING_SENSOR_GEN_ABORT_EN adds abort/aborted.
// ---------------------------------------------------------------------------
interface parking_sensor_gen_if #(parameter int DWELL_W = 8);

  logic               start;
  logic               dir;
  logic [DWELL_W-1:0] dwell;
  logic               ready;
  logic [1:0]         ab;
  logic               busy;
  logic               done;
`ifdef PARKING_SENSOR_GEN_ABORT_EN
  logic               abort;
  logic               aborted;
`endif

  modport master (
    output start, output dir, output dwell,
    input  ready, input ab, input busy, input done
`ifdef PARKING_SENSOR_GEN_ABORT_EN
    , output abort, input aborted
`endif
  );

  modport slave (
    input  start, input dir, input dwell,
    output ready, output ab, output busy, output done
`ifdef PARKING_SENSOR_GEN_ABORT_EN
    , input abort, output aborted
`endif
  );

endinterface

// File: rtl/parking_sensor_gen_dwell_timer.sv
// ---------------------------------------------------------------------------
// parking_dwell_timer
// Loadable down-counter timing one sensor phase.
//   clk, reset    : clock, synchronous active-high reset (clears the count)
//   load_i        : load load_val_i into the counter this edge
//   load_val_i    : phase length in cycles (>= 1)
//   expire_o      : high during the last cycle of the loaded phase
// ---------------------------------------------------------------------------
module parking_dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic [DWELL_W-1:0] load_val_i,
  output logic               expire_o
);

  localparam logic [DWELL_W-1:0] CNT_ZERO = {DWELL_W{1'b0}};
  localparam logic [DWELL_W-1:0] CNT_ONE  = DWELL_W'(1);

  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_d;

  // Next count: load wins, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != CNT_ZERO) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = CNT_ZERO;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A count of one means this is the final cycle of the phase.
  assign expire_o = (cnt_q == CNT_ONE);

endmodule

// File: rtl/parking_sensor_gen.sv
// ---------------------------------------------------------------------------
// parking_sensor_gen
// Emulates a car passing a two-beam parking sensor. On start the block walks
// through three phases (entry: 10,11,01 / exit: 01,11,10), each held for the
// sampled dwell count (0 acts as 1), then pulses done for one cycle.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : parking_sensor_gen_if.slave (start, dir, dwell -> ready, ab,
//           busy, done; plus abort -> aborted when enabled)
// Optional feature macro: PARKING_SENSOR_GEN_ABORT_EN enables back-out on abort.
// ---------------------------------------------------------------------------
module parking_sensor_gen
  import parking_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  parking_sensor_gen_if.slave  bus
);

  localparam logic [DWELL_W-1:0] DWELL_ZERO = {DWELL_W{1'b0}};
  localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);

  state_e             state_q, state_d;
  logic               dir_q, dir_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [1:0]         ab_q, ab_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef PARKING_SENSOR_GEN_ABORT_EN
  logic               aborted_q, aborted_d;
`endif

  logic               tmr_load_s;
  logic [DWELL_W-1:0] tmr_val_s;
  logic               tmr_expire_s;

  parking_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load_s),
    .load_val_i (tmr_val_s),
    .expire_o   (tmr_expire_s)
  );

  // Next-state, timer control and next-output decode.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    dwell_d    = dwell_q;
    tmr_load_s = 1'b0;
    tmr_val_s  = dwell_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d    = ST_P1;
          dir_d      = bus.dir;
          dwell_d    = (bus.dwell == DWELL_ZERO) ? DWELL_ONE : bus.dwell;
          tmr_load_s = 1'b1;
          tmr_val_s  = dwell_d;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_P1: begin
        if (tmr_expire_s) begin
          state_d    = ST_P2;
          tmr_load_s = 1'b1;
        end else begin
          state_d = ST_P1;
        end
      end
      ST_P2: begin
        if (tmr_expire_s) begin
          state_d    = ST_P3;
          tmr_load_s = 1'b1;
        end else begin
          state_d = ST_P2;
        end
      end
      ST_P3: begin
        if (tmr_expire_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_P3;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
`ifdef PARKING_SENSOR_GEN_ABORT_EN
      ST_BACK2: begin
        if (tmr_expire_s) begin
          state_d    = ST_BACK1;
          tmr_load_s = 1'b1;
        end else begin
          state_d = ST_BACK2;
        end
      end
      ST_BACK1: begin
        if (tmr_expire_s) begin
          state_d = ST_ABORTED;
        end else begin
          state_d = ST_BACK1;
        end
      end
      ST_ABORTED: begin
        state_d = ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef PARKING_SENSOR_GEN_ABORT_EN
    // Abort only matters in a forward phase; it overrides any phase expiry.
    if (bus.abort) begin
      case (state_q)
        ST_P1: begin
          state_d = ST_ABORTED;
        end
        ST_P2: begin
          state_d    = ST_BACK1;
          tmr_load_s = 1'b1;
        end
        ST_P3: begin
          state_d    = ST_BACK2;
          tmr_load_s = 1'b1;
        end
        default: begin
          state_d = state_d;
        end
      endcase
    end else begin
      state_d = state_d;
    end
`endif

    // Outputs are decoded from the next state so they register with it.
    ab_d    = phase_ab(state_d, dir_d);
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
`ifdef PARKING_SENSOR_GEN_ABORT_EN
    aborted_d = (state_d == ST_ABORTED);
`endif
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      dir_q     <= DIR_ENTRY;
      dwell_q   <= DWELL_ONE;
      ab_q      <= AB_NONE;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef PARKING_SENSOR_GEN_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      dwell_q   <= dwell_d;
      ab_q      <= ab_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef PARKING_SENSOR_GEN_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  assign bus.ab    = ab_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
`ifdef PARKING_SENSOR_GEN_ABORT_EN
  assign bus.aborted = aborted_q;
`endif

endmodule

// File: tb/tb_parking_sensor_gen.sv
// ---------------------------------------------------------------------------
// tb_parking_sensor_gen
// Scoreboard bench for parking_sensor_gen: each passage pushes its expected
// per-cycle outputs; a negedge monitor pops and compares them, checks that ab
// only ever changes one bit at a time, and feeds a small direction detector.
// Optional feature macro: PARKING_SENSOR_GEN_ABORT_EN enables back-out tests.
// ---------------------------------------------------------------------------
module tb_parking_sensor_gen;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  parking_sensor_gen_if #(.DWELL_W(DW)) bus ();

  parking_sensor_gen #(.DWELL_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [1:0] ab;
    logic       done;
    logic       busy;
    logic       ready;
    logic       aborted;
  } rec_t;

  rec_t exp_q[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   exp_entry = 0;
  int   exp_exit  = 0;
  int   det_entry = 0;
  int   det_exit  = 0;

  logic aborted_s;
`ifdef PARKING_SENSOR_GEN_ABORT_EN
  assign aborted_s = bus.aborted;
`else
  assign aborted_s = 1'b0;
`endif

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic rec_t mk(input logic [1:0] ab, input logic dn, input logic bs,
                              input logic rd, input logic abt);
    rec_t r;
    r.ab = ab; r.done = dn; r.busy = bs; r.ready = rd; r.aborted = abt;
    return r;
  endfunction

  // Expected beam pattern of forward phase 1..3 for a direction.
  function automatic logic [1:0] pat(input int ph, input logic d);
    logic [1:0] p;
    if (ph == 1)      p = d ? 2'b01 : 2'b10;
    else if (ph == 2) p = 2'b11;
    else              p = d ? 2'b10 : 2'b01;
    return p;
  endfunction

  // Monitor: scoreboard compare, one-bit-change check, direction detector.
  logic [1:0] prev_ab = 2'b00;
  logic [5:0] hist = 6'b0;
  int         hist_n = 0;
  always @(negedge clk) begin
    rec_t got;
    rec_t e;
    got = {bus.ab, bus.done, bus.busy, bus.ready, aborted_s};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_vec("seq", 32'(got), 32'(e));
    end
    if (!reset && (bus.ab != prev_ab))
      check_vec("gray", 32'($countones(bus.ab ^ prev_ab)), 32'd1);
    if (bus.ab == 2'b00) begin
      if (hist_n == 3 && hist == 6'b10_11_01) det_entry++;
      if (hist_n == 3 && hist == 6'b01_11_10) det_exit++;
      hist_n = 0;
      hist   = 6'b0;
    end else if (bus.ab != prev_ab) begin
      hist   = {hist[3:0], bus.ab};
      hist_n++;
    end
    prev_ab = bus.ab;
  end

  // mode: 0 normal, 1 keep start high, 2 extra start in P2,
  //       3 abort in first cycle of phase ph, 4 reset in first cycle of phase ph
  task automatic passage(input logic d, input int dw, input int mode, input int ph);
    int D;
    int n;
    D = (dw == 0) ? 1 : dw;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.dir   = d;
    bus.dwell = 8'(dw);
`ifdef PARKING_SENSOR_GEN_ABORT_EN
    if (mode == 0) bus.abort = 1'($urandom_range(0, 1));
`endif
    exp_q.push_back(mk(2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
    for (int p = 1; p <= 3; p++) begin
      if (mode >= 3 && p > ph) break;
      n = (mode >= 3 && p == ph) ? 1 : D;
      for (int k = 0; k < n; k++) exp_q.push_back(mk(pat(p, d), 1'b0, 1'b1, 1'b0, 1'b0));
    end
    if (mode == 3) begin
      for (int p = ph - 1; p >= 1; p--)
        for (int k = 0; k < D; k++) exp_q.push_back(mk(pat(p, d), 1'b0, 1'b1, 1'b0, 1'b0));
      exp_q.push_back(mk(2'b00, 1'b0, 1'b1, 1'b0, 1'b1));
    end else if (mode == 4) begin
      exp_q.push_back(mk(2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
    end else begin
      exp_q.push_back(mk(2'b00, 1'b1, 1'b1, 1'b0, 1'b0));
      if (d) exp_exit++; else exp_entry++;
    end

    @(posedge clk); #1;
    if (mode != 1) bus.start = 1'b0;
    bus.dir   = ~d;
    bus.dwell = 8'($urandom_range(0, 255));
`ifdef PARKING_SENSOR_GEN_ABORT_EN
    bus.abort = 1'b0;
`endif
    if (mode == 2) begin
      repeat (D) @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
    end
    if (mode == 3 || mode == 4) begin
      repeat ((ph - 1) * D) @(posedge clk);
      #1;
      if (mode == 4) begin
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
      end else begin
`ifdef PARKING_SENSOR_GEN_ABORT_EN
        bus.abort = 1'b1;
        repeat (2) @(posedge clk);
        #1 bus.abort = 1'b0;
`endif
      end
    end
`ifdef PARKING_SENSOR_GEN_ABORT_EN
    if (mode == 0 && D <= 4) begin
      repeat (3 * D) @(posedge clk);
      #1 bus.abort = 1'b1;
      @(posedge clk); #1 bus.abort = 1'b0;
    end
`endif
    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    if (exp_q.size() != 0) begin
      check_vec("drain", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    int de0, dx0, ee0, ex0;
    int m;
    bus.start = 1'b0;
    bus.dir   = 1'b0;
    bus.dwell = 8'd0;
`ifdef PARKING_SENSOR_GEN_ABORT_EN
    bus.abort = 1'b0;
`endif
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.push_back(mk(2'b00, 1'b0, 1'b0, 1'b1, 1'b0));

    passage(1'b0, 3, 0, 0);    // entry, 3 cycles per phase
    passage(1'b1, 0, 1, 0);    // exit, dwell 0, start held high
    passage(1'b1, 0, 0, 0);    // re-accepted right after DONE
    passage(1'b0, 4, 2, 0);    // stray start during P2
    passage(1'b1, 2, 2, 0);
    passage(1'b0, 5, 4, 3);    // reset during P3
    passage(1'b1, 3, 4, 1);    // reset during P1
    passage(1'b0, 255, 0, 0);  // longest dwell
`ifdef PARKING_SENSOR_GEN_ABORT_EN
    passage(1'b0, 2, 3, 3);    // back out from P3
    passage(1'b1, 3, 3, 2);    // back out from P2
    passage(1'b0, 1, 3, 1);    // back out from P1
    passage(1'b1, 0, 3, 3);
`endif

    de0 = det_entry; dx0 = det_exit; ee0 = exp_entry; ex0 = exp_exit;
    for (int i = 0; i < 200; i++) begin
      m = 0;
`ifdef PARKING_SENSOR_GEN_ABORT_EN
      if ($urandom_range(0, 3) == 0) m = 3;
`endif
      passage(1'($urandom_range(0, 1)), $urandom_range(0, 4), m, $urandom_range(1, 3));
    end
    check_vec("det_entry", 32'(det_entry - de0), 32'(exp_entry - ee0));
    check_vec("det_exit",  32'(det_exit - dx0),  32'(exp_exit - ex0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
